// File: rtl/text_pkg.sv
// Shared ASCII constants and FSM state encoding for the text console buffer.
package text_pkg;

  localparam logic [6:0] SPACE    = 7'h20;
  localparam logic [6:0] CR       = 7'h0D;
  localparam logic [6:0] LF       = 7'h0A;
  localparam logic [6:0] BS       = 7'h08;
  localparam logic [6:0] FF       = 7'h0C;
  localparam logic [6:0] PRINT_LO = 7'h20;
  localparam logic [6:0] PRINT_HI = 7'h7E;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL,
    ST_CLRLINE
  } state_t;

endpackage

// File: rtl/text_ram.sv
// Character store: one synchronous write port, two synchronous read ports
// (scroll copy and display). Contents are not reset.
module text_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [6:0]    wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [6:0]    ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [6:0]    rb_data
);

  logic [6:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    ra_data <= mem[ra_addr];
    rb_data <= mem[rb_addr];
  end

endmodule

// File: rtl/text_console_buffer.sv
// ROWS x COLS character screen fed by UART bytes: cursor, wrap, CR/LF, backspace,
// form-feed clear and hardware scroll, plus a received-byte history for the 7-seg.
module text_console_buffer
  import text_pkg::*;
#(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int HEX_BYTES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  output logic [6:0]                rd_char,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic [8*HEX_BYTES-1:0]    hex_hist,
  output logic                      busy,
  output logic                      rx_dropped
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);

  localparam logic [AW-1:0] LAST_A   = AW'(CELLS - 1);
  localparam logic [AW-1:0] SCROLL_N = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] COLS_A   = AW'(COLS);
  localparam logic [AW-1:0] COLS_M1  = AW'(COLS - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;
  logic [6:0]    pend_char, pend_nxt;
  logic          pend_adv, adv_nxt;
  logic          rd_vld;

  logic          we;
  logic [AW-1:0] waddr, srd_addr, disp_addr, cur_addr;
  logic [6:0]    wdata, srd_data, disp_data;
  logic [6:0]    rx_char;
  logic          accept;

  assign rx_char   = rx_data[6:0];
  assign cur_addr  = AW'(cursor_row) * COLS_A + AW'(cursor_col);
  assign disp_addr = AW'(rd_row) * COLS_A + AW'(rd_col);
  assign accept    = rx_valid && rx_ready;
  // RAM output is not resettable; mask it until the first clock after reset
  assign rd_char   = rd_vld ? disp_data : '0;

  text_ram #(
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .ra_addr (srd_addr),
    .ra_data (srd_data),
    .rb_addr (disp_addr),
    .rb_data (disp_data)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    col_nxt   = cursor_col;
    row_nxt   = cursor_row;
    pend_nxt  = pend_char;
    adv_nxt   = pend_adv;
    we        = 1'b0;
    waddr     = cur_addr;
    wdata     = SPACE;
    rx_ready  = 1'b0;
    busy      = 1'b0;
    srd_addr  = (cnt < SCROLL_N) ? cnt + COLS_A : '0;

    unique case (state)
      ST_CLEAR: begin
        busy    = 1'b1;
        we      = 1'b1;
        waddr   = cnt;
        col_nxt = '0;
        row_nxt = '0;
        if (cnt == LAST_A) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_char >= PRINT_LO && rx_char <= PRINT_HI) begin
            pend_nxt  = rx_char;
            adv_nxt   = 1'b1;
            state_nxt = ST_WRITE;
          end else if (rx_char == CR) begin
            col_nxt = '0;
          end else if (rx_char == LF) begin
            if (cursor_row < ROW_MAX) begin
              row_nxt = cursor_row + 1'b1;
            end else begin
              cnt_nxt   = '0;
              state_nxt = ST_SCROLL;
            end
          end else if (rx_char == BS) begin
            if (cursor_col != '0) begin
              col_nxt   = cursor_col - 1'b1;
              pend_nxt  = SPACE;
              adv_nxt   = 1'b0;
              state_nxt = ST_WRITE;
            end
          end else if (rx_char == FF) begin
            cnt_nxt   = '0;
            col_nxt   = '0;
            row_nxt   = '0;
            state_nxt = ST_CLEAR;
          end
        end
      end

      ST_WRITE: begin
        we        = 1'b1;
        wdata     = pend_char;
        state_nxt = ST_IDLE;
        if (pend_adv) begin
          if (cursor_col < COL_MAX) begin
            col_nxt = cursor_col + 1'b1;
          end else begin
            col_nxt = '0;
            if (cursor_row < ROW_MAX) begin
              row_nxt = cursor_row + 1'b1;
            end else begin
              cnt_nxt   = '0;
              state_nxt = ST_SCROLL;
            end
          end
        end
      end

      ST_SCROLL: begin
        // read a+COLS on cycle a, write it to a one cycle later
        busy = 1'b1;
        if (cnt != '0) begin
          we    = 1'b1;
          waddr = cnt - 1'b1;
          wdata = srd_data;
        end
        if (cnt == SCROLL_N) begin
          cnt_nxt   = '0;
          state_nxt = ST_CLRLINE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_CLRLINE: begin
        busy  = 1'b1;
        we    = 1'b1;
        waddr = SCROLL_N + cnt;
        if (cnt == COLS_M1) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_CLEAR;
      cnt        <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      pend_char  <= SPACE;
      pend_adv   <= 1'b0;
      hex_hist   <= '0;
      rx_dropped <= 1'b0;
      rd_vld     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cursor_col <= col_nxt;
      cursor_row <= row_nxt;
      pend_char  <= pend_nxt;
      pend_adv   <= adv_nxt;
      rd_vld     <= 1'b1;
      if (accept) begin
        for (int unsigned i = 1; i < HEX_BYTES; i++) begin
          hex_hist[8*i +: 8] <= hex_hist[8*(i-1) +: 8];
        end
        hex_hist[7:0] <= rx_data;
      end
      if (rx_valid && !rx_ready) rx_dropped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_text_console_buffer.sv
// Directed bench for text_console_buffer at COLS=4, ROWS=3, HEX_BYTES=2.
module tb_text_console_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic [1:0]  rd_col = '0;
  logic [1:0]  rd_row = '0;
  logic [6:0]  rd_char;
  logic [1:0]  cursor_col;
  logic [1:0]  cursor_row;
  logic [15:0] hex_hist;
  logic        busy;
  logic        rx_dropped;

  int n_cmp = 0;
  int n_err = 0;

  text_console_buffer #(
    .COLS      (4),
    .ROWS      (3),
    .HEX_BYTES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_char    (rd_char),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .hex_hist   (hex_hist),
    .busy       (busy),
    .rx_dropped (rx_dropped)
  );

  always #5 clk = ~clk;

  task automatic read_cell(input int r, input int c, output logic [6:0] ch);
    rd_row = 2'(r);
    rd_col = 2'(c);
    @(negedge clk);
    ch = rd_char;
  endtask

  // Offer one byte when rx_ready; optionally wait for the block to return to IDLE.
  task automatic send_byte(input logic [7:0] b, input bit wait_idle);
    int n = 0;
    while (!rx_ready && n < 200) begin @(negedge clk); n++; end
    if (!rx_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_ready_timeout: rx_ready=%0b required 1", rx_ready);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    if (wait_idle) begin
      n = 0;
      while (!rx_ready && n < 200) begin @(negedge clk); n++; end
    end
  endtask

  task automatic test_reset();
    int n;
    logic [6:0] ch;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_char !== 7'h00) begin n_err++; $display("FAIL reset_rd_char: got %h want 00", rd_char); end
    n_cmp++; if (busy !== 1'b1 || rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_busy_ready: got busy=%b ready=%b want 1/0", busy, rx_ready); end
    n_cmp++; if ({cursor_row, cursor_col, hex_hist, rx_dropped} !== 21'd0) begin n_err++; $display("FAIL reset_state: got row=%0d col=%0d hex=%h drop=%b want zeros", cursor_row, cursor_col, hex_hist, rx_dropped); end
    reset = 1'b1;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 12) begin n_err++; $display("FAIL reset_clear_cycles: got %0d want 12", n); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b want 1", rx_ready); end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        read_cell(r, c, ch);
        n_cmp++; if (ch !== 7'h20) begin n_err++; $display("FAIL reset_cell(%0d,%0d): got %h want 20", r, c, ch); end
      end
  endtask

  task automatic test_wrap();
    logic [6:0] ch;
    logic [6:0] exp [8];
    exp = '{7'h41, 7'h42, 7'h43, 7'h44, 7'h45, 7'h20, 7'h20, 7'h20};
    send_byte("A", 1); send_byte("B", 1); send_byte("C", 1);
    send_byte("D", 1); send_byte("E", 1);
    for (int i = 0; i < 8; i++) begin
      read_cell(i / 4, i % 4, ch);
      n_cmp++; if (ch !== exp[i]) begin n_err++; $display("FAIL wrap_cell(%0d,%0d): got %h want %h", i / 4, i % 4, ch, exp[i]); end
    end
    n_cmp++; if (cursor_row !== 2'd1 || cursor_col !== 2'd1) begin n_err++; $display("FAIL wrap_cursor: got (%0d,%0d) want (1,1)", cursor_row, cursor_col); end
    n_cmp++; if (hex_hist !== 16'h4445) begin n_err++; $display("FAIL wrap_hex: got %h want 4445", hex_hist); end
  endtask

  task automatic test_scroll_drop();
    int n, g;
    logic [6:0] ch;
    logic [6:0] exp [12];
    exp = '{7'h45, 7'h20, 7'h20, 7'h20,
            7'h20, 7'h50, 7'h51, 7'h5A,
            7'h20, 7'h20, 7'h20, 7'h20};
    send_byte(8'h0A, 1); send_byte("P", 1); send_byte("Q", 1);
    n_cmp++; if (cursor_row !== 2'd2 || cursor_col !== 2'd3) begin n_err++; $display("FAIL scroll_pre_cursor: got (%0d,%0d) want (2,3)", cursor_row, cursor_col); end
    send_byte("Z", 0);
    g = 0;
    while (!busy && g < 10) begin @(negedge clk); g++; end
    n = 0;
    while (busy && n < 100) begin
      n++;
      n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL scroll_ready_low: got %b want 0", rx_ready); end
      rx_data  = "K";
      rx_valid = (n == 3);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    n_cmp++; if (n !== 13) begin n_err++; $display("FAIL scroll_busy_cycles: got %0d want 13", n); end
    n_cmp++; if (rx_dropped !== 1'b1) begin n_err++; $display("FAIL scroll_dropped: got %b want 1", rx_dropped); end
    n_cmp++; if (hex_hist !== 16'h515A) begin n_err++; $display("FAIL scroll_hex: got %h want 515A", hex_hist); end
    n_cmp++; if (cursor_row !== 2'd2 || cursor_col !== 2'd0) begin n_err++; $display("FAIL scroll_cursor: got (%0d,%0d) want (2,0)", cursor_row, cursor_col); end
    for (int i = 0; i < 12; i++) begin
      read_cell(i / 4, i % 4, ch);
      n_cmp++; if (ch !== exp[i]) begin n_err++; $display("FAIL scroll_cell(%0d,%0d): got %h want %h", i / 4, i % 4, ch, exp[i]); end
    end
  endtask

  task automatic test_backspace();
    logic [6:0] ch;
    send_byte("A", 1);
    read_cell(2, 0, ch);
    n_cmp++; if (ch !== 7'h41) begin n_err++; $display("FAIL bs_pre_cell: got %h want 41", ch); end
    send_byte(8'h08, 1);
    read_cell(2, 0, ch);
    n_cmp++; if (ch !== 7'h20) begin n_err++; $display("FAIL bs_cell: got %h want 20", ch); end
    n_cmp++; if (cursor_row !== 2'd2 || cursor_col !== 2'd0) begin n_err++; $display("FAIL bs_cursor: got (%0d,%0d) want (2,0)", cursor_row, cursor_col); end
    send_byte(8'h08, 1);
    n_cmp++; if (cursor_row !== 2'd2 || cursor_col !== 2'd0) begin n_err++; $display("FAIL bs_noop_cursor: got (%0d,%0d) want (2,0)", cursor_row, cursor_col); end
    read_cell(1, 3, ch);
    n_cmp++; if (ch !== 7'h5A) begin n_err++; $display("FAIL bs_noop_neighbour: got %h want 5A", ch); end
    n_cmp++; if (hex_hist !== 16'h0808 || rx_dropped !== 1'b1) begin n_err++; $display("FAIL bs_hex_drop: got hex=%h drop=%b want 0808/1", hex_hist, rx_dropped); end
  endtask

  task automatic test_formfeed();
    int n;
    logic [6:0] ch;
    send_byte("M", 1); send_byte("N", 1); send_byte(8'h0D, 1);
    n_cmp++; if (cursor_row !== 2'd2 || cursor_col !== 2'd0) begin n_err++; $display("FAIL cr_cursor: got (%0d,%0d) want (2,0)", cursor_row, cursor_col); end
    send_byte(8'h01, 1);
    read_cell(2, 1, ch);
    n_cmp++; if (ch !== 7'h4E) begin n_err++; $display("FAIL ctl_cell: got %h want 4E", ch); end
    n_cmp++; if (hex_hist !== 16'h0D01 || cursor_col !== 2'd0) begin n_err++; $display("FAIL ctl_ignored: got hex=%h col=%0d want 0D01/0", hex_hist, cursor_col); end
    send_byte(8'h0C, 0);
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    n_cmp++; if (n !== 12) begin n_err++; $display("FAIL ff_busy_cycles: got %0d want 12", n); end
    n_cmp++; if (cursor_row !== 2'd0 || cursor_col !== 2'd0 || hex_hist !== 16'h010C) begin n_err++; $display("FAIL ff_state: got (%0d,%0d) hex=%h want (0,0) 010C", cursor_row, cursor_col, hex_hist); end
    for (int i = 0; i < 12; i++) begin
      read_cell(i / 4, i % 4, ch);
      n_cmp++; if (ch !== 7'h20) begin n_err++; $display("FAIL ff_cell(%0d,%0d): got %h want 20", i / 4, i % 4, ch); end
    end
  endtask

  task automatic test_reset_mid_scroll();
    int n;
    logic [6:0] ch;
    send_byte(8'h0A, 1); send_byte("R", 1); send_byte(8'h0A, 1);
    send_byte(8'h0A, 0);
    @(negedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || cursor_row !== 2'd2) begin n_err++; $display("FAIL rms_in_scroll: got busy=%b row=%0d want 1/2", busy, cursor_row); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({cursor_row, cursor_col, hex_hist, rx_dropped} !== 21'd0) begin n_err++; $display("FAIL rms_reset_state: got row=%0d col=%0d hex=%h drop=%b want zeros", cursor_row, cursor_col, hex_hist, rx_dropped); end
    n_cmp++; if (busy !== 1'b1 || rx_ready !== 1'b0 || rd_char !== 7'h00) begin n_err++; $display("FAIL rms_reset_outputs: got busy=%b ready=%b rd=%h want 1/0/00", busy, rx_ready, rd_char); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 12) begin n_err++; $display("FAIL rms_clear_cycles: got %0d want 12", n); end
    for (int i = 0; i < 12; i++) begin
      read_cell(i / 4, i % 4, ch);
      n_cmp++; if (ch !== 7'h20) begin n_err++; $display("FAIL rms_cell(%0d,%0d): got %h want 20", i / 4, i % 4, ch); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_wrap();
    test_scroll_drop();
    test_backspace();
    test_formfeed();
    test_reset_mid_scroll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
